// File: rtl/stage_pipe_fifo.sv
// stage_pipe_fifo: DEPTH-entry valid/ready inter-stage channel tagged with pc,
// with synchronous flush and a saturating count of squashed entries.
module stage_pipe_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  flush,
    output logic [CNT_W-1:0]      count,
    output logic [7:0]            drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = CNT_W + 9;

    logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wrPtr, rdPtr;
    logic push, pop;
    logic [SW-1:0] dropSum;

    // Ready depends on the occupancy register only, so out_ready never reaches in_ready.
    assign in_ready  = count != CNT_W'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;
    assign {out_pc, out_data} = out_valid ? mem[rdPtr] : '0;
    assign dropSum   = SW'(drop_cnt) + SW'(count) - SW'(pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            drop_cnt <= dropSum > SW'(255) ? 8'd255 : dropSum[7:0];
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop) rdPtr <= rdPtr + PW'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wrPtr] <= {in_pc, in_data};
endmodule

// File: tb/tb_stage_pipe_fifo.sv
// tb_stage_pipe_fifo: directed checks of a DEPTH=2 and a DEPTH=4 channel.
module tb_stage_pipe_fifo;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    logic v2 = 0, rdy2 = 0, fl2 = 0, ir2, ov2;
    logic [31:0] pc2 = 0, dat2 = 0, opc2, odat2;
    logic [1:0] cnt2;
    logic [7:0] drop2;

    logic v4 = 0, rdy4 = 0, fl4 = 0, ir4, ov4;
    logic [31:0] pc4 = 0, dat4 = 0, opc4, odat4;
    logic [2:0] cnt4;
    logic [7:0] drop4;

    int total = 0;
    int bad = 0;

    stage_pipe_fifo #(.DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(ir2), .in_pc(pc2), .in_data(dat2),
        .out_valid(ov2), .out_ready(rdy2), .out_pc(opc2), .out_data(odat2), .flush(fl2),
        .count(cnt2), .drop_cnt(drop2)
    );

    stage_pipe_fifo #(.DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(ir4), .in_pc(pc4), .in_data(dat4),
        .out_valid(ov4), .out_ready(rdy4), .out_pc(opc4), .out_data(odat4), .flush(fl4),
        .count(cnt4), .drop_cnt(drop4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rdy2 = 0; v2 = 1; pc2 = 32'h11; tick;
        pc2 = 32'h22; tick;
        v2 = 0;
        total++; if (cnt2 !== 2'd2) begin bad++; $display("FAIL rst_prefill count got %0d want 2", cnt2); end
        #2 rst_n = 0;
        #1;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", ov2); end
        total++; if (cnt2 !== 2'd0) begin bad++; $display("FAIL rst_count got %0d want 0", cnt2); end
        total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL rst_in_ready got %b want 1", ir2); end
        total++; if (drop2 !== 8'd0) begin bad++; $display("FAIL rst_drop got %0d want 0", drop2); end
        total++; if (opc2 !== 32'h0) begin bad++; $display("FAIL rst_out_pc got %h want 0", opc2); end
        tick;
        rst_n = 1;
        tick;
    endtask

    task automatic test_order_latency;
        rdy2 = 1; v2 = 1; pc2 = 32'h80000000; dat2 = 32'hA5A50000;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL ord_no_bypass got %b want 0", ov2); end
        tick;
        total++; if (opc2 !== 32'h80000000) begin bad++; $display("FAIL ord_first_pc got %h want 80000000", opc2); end
        total++; if (odat2 !== 32'hA5A50000) begin bad++; $display("FAIL ord_first_data got %h want a5a50000", odat2); end
        total++; if (cnt2 !== 2'd1) begin bad++; $display("FAIL ord_count1 got %0d want 1", cnt2); end
        pc2 = 32'h80000004; dat2 = 32'hA5A50004;
        tick;
        v2 = 0;
        total++; if (opc2 !== 32'h80000004) begin bad++; $display("FAIL ord_second_pc got %h want 80000004", opc2); end
        total++; if (cnt2 !== 2'd1) begin bad++; $display("FAIL ord_count_peak got %0d want 1", cnt2); end
        tick;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL ord_drained got %b want 0", ov2); end
    endtask

    task automatic test_full_backpressure;
        rdy2 = 0; v2 = 1; pc2 = 32'hA0; tick;
        pc2 = 32'hB0; tick;
        total++; if (ir2 !== 1'b0) begin bad++; $display("FAIL full_in_ready got %b want 0", ir2); end
        total++; if (cnt2 !== 2'd2) begin bad++; $display("FAIL full_count got %0d want 2", cnt2); end
        pc2 = 32'hC0; tick;
        total++; if (cnt2 !== 2'd2) begin bad++; $display("FAIL full_held_count got %0d want 2", cnt2); end
        total++; if (opc2 !== 32'hA0) begin bad++; $display("FAIL full_stable_pc got %h want a0", opc2); end
        rdy2 = 1; tick;
        total++; if (opc2 !== 32'hB0) begin bad++; $display("FAIL full_second_pc got %h want b0", opc2); end
        total++; if (cnt2 !== 2'd1) begin bad++; $display("FAIL full_after_pop got %0d want 1", cnt2); end
        total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL full_ready_back got %b want 1", ir2); end
        tick;
        v2 = 0;
        total++; if (opc2 !== 32'hC0) begin bad++; $display("FAIL full_third_pc got %h want c0", opc2); end
        tick;
        total++; if (cnt2 !== 2'd0) begin bad++; $display("FAIL full_drained got %0d want 0", cnt2); end
    endtask

    task automatic test_flush;
        rdy2 = 0; v2 = 1; pc2 = 32'h100; tick;
        pc2 = 32'h104; tick;
        rdy2 = 1; v2 = 1; pc2 = 32'h108; fl2 = 1;
        total++; if (opc2 !== 32'h100) begin bad++; $display("FAIL fl_head_pc got %h want 100", opc2); end
        tick;
        fl2 = 0; v2 = 0;
        total++; if (cnt2 !== 2'd0) begin bad++; $display("FAIL fl_count got %0d want 0", cnt2); end
        total++; if (drop2 !== 8'd1) begin bad++; $display("FAIL fl_drop got %0d want 1", drop2); end
        total++; if (opc2 !== 32'h0) begin bad++; $display("FAIL fl_gated_pc got %h want 0", opc2); end
        tick;
        total++; if (ov2 !== 1'b0) begin bad++; $display("FAIL fl_beat_absent got %b want 0", ov2); end
    endtask

    task automatic test_wrap;
        logic [31:0] q[$];
        int sent = 0;
        int recv = 0;
        bit push, pop;
        void'($urandom(32'hC0FFEE));
        for (int cyc = 0; cyc < 200 && recv < 10; cyc++) begin
            v4 = sent < 10;
            pc4 = 32'h80000000 + 32'(4 * sent);
            rdy4 = 1'($urandom_range(0, 1));
            push = v4 && ir4;
            pop = ov4 && rdy4;
            if (pop) begin
                total++; if (opc4 !== q[0]) begin bad++; $display("FAIL wrap_pc got %h want %h", opc4, q[0]); end
                void'(q.pop_front());
                recv++;
            end
            if (push) begin
                q.push_back(pc4);
                sent++;
            end
            tick;
            total++; if (cnt4 > 3'd4 || 32'(cnt4) != q.size()) begin bad++; $display("FAIL wrap_count got %0d want %0d", cnt4, q.size()); end
        end
        v4 = 0; rdy4 = 0;
        total++; if (recv != 10) begin bad++; $display("FAIL wrap_timeout got %0d want 10", recv); end
    endtask

    task automatic test_saturation;
        for (int i = 1; i <= 130; i++) begin
            rdy2 = 0; v2 = 1; pc2 = 32'(i); tick;
            tick;
            v2 = 0; fl2 = 1; tick;
            fl2 = 0;
            if (i == 126) begin
                total++; if (drop2 !== 8'd253) begin bad++; $display("FAIL sat_mid got %0d want 253", drop2); end
            end
        end
        total++; if (drop2 !== 8'd255) begin bad++; $display("FAIL sat_hold got %0d want 255", drop2); end
        total++; if (cnt2 !== 2'd0) begin bad++; $display("FAIL sat_count got %0d want 0", cnt2); end
    endtask

    task automatic test_reset_clears_drop;
        #2 rst_n = 0;
        #1;
        total++; if (drop2 !== 8'd0) begin bad++; $display("FAIL rst2_drop got %0d want 0", drop2); end
        tick;
        rst_n = 1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        tick;
        test_reset;
        test_order_latency;
        test_full_backpressure;
        test_flush;
        test_wrap;
        test_saturation;
        test_reset_clears_drop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
